i2c_target_regfile: RTL

I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

---
 rtl/i2c_target_regfile.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing an 8-bit register file with auto-incrementing pointer
// Optional general-call support: define I2C_GENCALL_EN.
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h20,
    parameter int         REG_COUNT   = 32,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   sda_oe,
    output logic [8*REG_COUNT-1:0] regs_packed,
    output logic                   wr_strobe,
    output logic [7:0]             wr_index,
    output logic                   busy
);

    localparam int         IW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [8:0] REG_LIMIT = 9'(REG_COUNT);
    localparam logic [7:0] PTR_LAST  = 8'(REG_COUNT - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl_s, sda_s, scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SCL must be high on both samples so a data change racing an SCL edge is not a START/STOP
    assign bus_start = scl_s & scl_d & ~sda_s & sda_d;
    assign bus_stop  = scl_s & scl_d & sda_s & ~sda_d;

    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n, tx, tx_n, ptr, ptr_n;
    logic       rw, rw_n, mack, mack_n, sda_oe_n, wr_en;
    logic [7:0] regs [REG_COUNT];
    logic [7:0] ptr_inc, rd_cur, rd_next;
    logic       addr_hit;

    assign ptr_inc = (ptr == PTR_LAST) ? 8'd0 : ptr + 8'd1;
    assign rd_cur  = regs[ptr[IW-1:0]];
    assign rd_next = regs[ptr_inc[IW-1:0]];

`ifdef I2C_GENCALL_EN
    assign addr_hit = (shift[7:1] == TARGET_ADDR) || (shift == 8'h00);
`else
    assign addr_hit = (shift[7:1] == TARGET_ADDR);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shift   <= 8'h00;
            tx      <= 8'h00;
            ptr     <= 8'h00;
            rw      <= 1'b0;
            mack    <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            tx      <= tx_n;
            ptr     <= ptr_n;
            rw      <= rw_n;
            mack    <= mack_n;
            sda_oe  <= sda_oe_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        tx_n      = tx;
        ptr_n     = ptr;
        rw_n      = rw;
        mack_n    = mack;
        sda_oe_n  = sda_oe;
        wr_en     = 1'b0;
        if (bus_start) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
        end else if (bus_stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
        end else begin
            // receive states share the shift-in path; decisions happen on the fall after bit 8
            if ((state == ADDR || state == PTR || state == WDATA) && scl_rise && bit_cnt < 4'd8) begin
                shift_n   = {shift[6:0], sda_s};
                bit_cnt_n = bit_cnt + 4'd1;
            end
            case (state)
                ADDR: if (scl_fall && bit_cnt == 4'd8) begin
                    if (addr_hit) begin
                        state_n  = ADDR_ACK;
                        rw_n     = shift[0];
                        sda_oe_n = 1'b1;
                    end else begin
                        state_n  = IGNORE;
                        sda_oe_n = 1'b0;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    bit_cnt_n = 4'd0;
                    if (rw) begin
                        state_n  = RDATA;
                        sda_oe_n = ~rd_cur[7];
                        tx_n     = {rd_cur[6:0], 1'b0};
                    end else begin
                        state_n  = PTR;
                        sda_oe_n = 1'b0;
                    end
                end
                PTR: if (scl_fall && bit_cnt == 4'd8) begin
                    if ({1'b0, shift} < REG_LIMIT) begin
                        state_n  = PTR_ACK;
                        ptr_n    = shift;
                        sda_oe_n = 1'b1;
                    end else begin
                        state_n  = IGNORE;
                        sda_oe_n = 1'b0;
                    end
                end
                PTR_ACK: if (scl_fall) begin
                    state_n   = WDATA;
                    bit_cnt_n = 4'd0;
                    sda_oe_n  = 1'b0;
                end
                WDATA: if (scl_fall && bit_cnt == 4'd8) begin
                    state_n  = WDATA_ACK;
                    sda_oe_n = 1'b1;
                end
                WDATA_ACK: if (scl_fall) begin
                    wr_en     = 1'b1;
                    ptr_n     = ptr_inc;
                    state_n   = WDATA;
                    bit_cnt_n = 4'd0;
                    sda_oe_n  = 1'b0;
                end
                RDATA: begin
                    if (scl_rise) bit_cnt_n = bit_cnt + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n  = RACK;
                            sda_oe_n = 1'b0;
                        end else begin
                            sda_oe_n = ~tx[7];
                            tx_n     = {tx[6:0], 1'b0};
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) mack_n = ~sda_s;
                    if (scl_fall) begin
                        if (mack) begin
                            state_n   = RDATA;
                            bit_cnt_n = 4'd0;
                            ptr_n     = ptr_inc;
                            sda_oe_n  = ~rd_next[7];
                            tx_n      = {rd_next[6:0], 1'b0};
                        end else begin
                            state_n  = IGNORE;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
            wr_strobe <= 1'b0;
            wr_index  <= 8'h00;
        end else begin
            wr_strobe <= wr_en;
            if (wr_en) begin
                regs[ptr[IW-1:0]] <= shift;
                wr_index          <= ptr;
            end
        end
    end

    for (genvar k = 0; k < REG_COUNT; k++) begin : g_pack
        assign regs_packed[8*k +: 8] = regs[k];
    end

    assign busy = (state != IDLE) && (state != IGNORE);

endmodule
